// File: rtl/srp16_pkg.sv
// Shared types and helpers for the SRP16 byte-serial memory bridge.
package srp16_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ISSUE,
    READ_WAIT,
    RESP
  } bridge_state_t;

  localparam int BYTE_W = 8;

  function automatic int bytes_of(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Width of a byte count that can hold 0..BYTES.
  function automatic int size_w_of(input int data_w);
    return $clog2(data_w / BYTE_W + 1);
  endfunction

  // Word byte position that memory transfer k of an n-byte access maps to.
  function automatic int lane_index(input int k, input int n, input logic big_endian);
    return big_endian ? (n - 1 - k) : k;
  endfunction

endpackage

// File: rtl/srp16_byte_packer.sv
// Combinational read assembly: keep the low n bytes, zero- or sign-fill the rest.
module srp16_byte_packer
  import srp16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SZ_W   = size_w_of(DATA_W)
) (
  input  logic [DATA_W-1:0] bytes_in,
  input  logic [SZ_W-1:0]   n,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] result
);

  localparam int BYTES = bytes_of(DATA_W);

  logic fill;

  // Copy requested bytes, pick the fill bit from byte n-1, then pad upward.
  always_comb begin
    result = '0;
    fill   = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (i < int'(n)) result[BYTE_W*i +: BYTE_W] = bytes_in[BYTE_W*i +: BYTE_W];
      if (i == int'(n) - 1) fill = sign_ext & bytes_in[BYTE_W*i + BYTE_W - 1];
    end
    for (int i = 0; i < BYTES; i++) begin
      if (i >= int'(n)) result[BYTE_W*i +: BYTE_W] = {BYTE_W{fill}};
    end
  end

endmodule

// File: rtl/srp16_mem_bridge.sv
// Word request to byte-serial memory access sequencer with configurable read latency.
module srp16_mem_bridge
  import srp16_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int BIG_ENDIAN = 0,
  localparam int BYTES     = bytes_of(DATA_W),
  localparam int SZ_W      = size_w_of(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_signed,
  input  logic [SZ_W-1:0]   req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  bridge_state_t     state, state_n;
  logic [SZ_W-1:0]   k, k_n, n_q, n_src, size_norm;
  logic [2:0]        lat, lat_n;
  logic [ADDR_W-1:0] addr_q, addr_src;
  logic [DATA_W-1:0] wdata_q, wdata_src, cap_q, cap_n, packed_w;
  logic              sign_q, sign_src;
  logic [7:0]        wr_byte;
  int                rd_lane, wr_lane;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign size_norm = (req_size == '0 || req_size > SZ_W'(BYTES)) ? SZ_W'(BYTES) : req_size;

  srp16_byte_packer #(.DATA_W(DATA_W), .SZ_W(SZ_W)) u_packer (
    .bytes_in (cap_n),
    .n        (n_q),
    .sign_ext (sign_q),
    .result   (packed_w)
  );

  // Next-state, byte/latency counters, capture merge and next outgoing byte.
  always_comb begin
    state_n   = state;
    k_n       = k;
    lat_n     = lat;
    addr_src  = addr_q;
    wdata_src = wdata_q;
    n_src     = n_q;
    sign_src  = sign_q;
    cap_n     = cap_q;
    rd_lane   = lane_index(int'(k), int'(n_q), BIG_ENDIAN != 0);
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_n   = req_write ? WRITE : READ_ISSUE;
          k_n       = '0;
          lat_n     = '0;
          addr_src  = req_addr;
          wdata_src = req_wdata;
          n_src     = size_norm;
          sign_src  = req_signed;
          cap_n     = '0;
        end
      end
      WRITE: begin
        k_n = k + SZ_W'(1);
        if (k_n == n_q) state_n = RESP;
      end
      READ_ISSUE: begin
        state_n = READ_WAIT;
        lat_n   = '0;
      end
      READ_WAIT: begin
        if (lat == 3'(MEM_LAT - 1)) begin
          for (int i = 0; i < BYTES; i++) begin
            if (i == rd_lane) cap_n[BYTE_W*i +: BYTE_W] = mem_rdata;
          end
          k_n     = k + SZ_W'(1);
          state_n = (k_n == n_q) ? RESP : READ_ISSUE;
        end else begin
          lat_n = lat + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Past the last byte the lane may fall outside the word; any value is fine there.
    wr_lane = lane_index(int'(k_n), int'(n_src), BIG_ENDIAN != 0);
    if (wr_lane < 0) wr_lane = 0;
    wr_byte = 8'(wdata_src >> (BYTE_W * wr_lane));
  end

  // Control state and registered memory/response outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k         <= '0;
      lat       <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      lat       <= lat_n;
      mem_we    <= (state_n == WRITE);
      mem_re    <= (state_n == READ_ISSUE);
      mem_addr  <= addr_src + ADDR_W'(k_n);
      mem_wdata <= wr_byte;
      if (state == WRITE && state_n == RESP) rsp_rdata <= '0;
      else if (state == READ_WAIT && state_n == RESP) rsp_rdata <= packed_w;
    end
  end

  // Request fields and captured read bytes; always overwritten before use.
  always_ff @(posedge clk) begin
    addr_q  <= addr_src;
    wdata_q <= wdata_src;
    n_q     <= n_src;
    sign_q  <= sign_src;
    cap_q   <= cap_n;
  end

endmodule

// File: tb/tb_srp16_mem_bridge.sv
// Scoreboard bench: two bridges (little-endian latency 1, big-endian latency 2).
module tb_srp16_mem_bridge;

  localparam int LAT_0 = 1;
  localparam int LAT_1 = 2;

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_0 : LAT_1;
  endfunction

  function automatic bit be_of(input int d);
    return (d == 1);
  endfunction

  typedef struct { int d; logic [15:0] addr; logic [7:0] data; int cyc; } mev_t;
  typedef struct { int d; logic [15:0] data; int cyc; } rev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0]       req_valid = '0, req_write = '0, req_signed = '0, rsp_ready = '0;
  logic [1:0][1:0]  req_size = '0;
  logic [1:0][15:0] req_addr = '0, req_wdata = '0;
  logic [1:0][7:0]  mem_rdata = '0;
  wire  [1:0]       req_ready, rsp_valid, mem_we, mem_re;
  wire  [1:0][15:0] rsp_rdata, mem_addr;
  wire  [1:0][7:0]  mem_wdata;

  bit [7:0] mem  [2][65536];
  bit [7:0] refm [2][65536];
  bit        pv [2][4];
  bit [15:0] pa [2][4];

  mev_t wq[$], rq[$];
  rev_t sq[$];
  int cyc = 0;
  int checks = 0, passes = 0;
  int tmo_req = 0, tmo_seen = 0;
  bit done = 0, finished = 0;
  bit hold [2];
  bit exp_rdy [2];
  logic [15:0] held [2];

  srp16_mem_bridge #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT_0), .BIG_ENDIAN(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_signed(req_signed[0]), .req_size(req_size[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_rdata(mem_rdata[0]));

  srp16_mem_bridge #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT_1), .BIG_ENDIAN(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_signed(req_signed[1]), .req_size(req_size[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_rdata(mem_rdata[1]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Memory models and monitor: all checking happens here, mid-cycle.
  always @(negedge clk) begin
    mev_t e;
    rev_t r;
    for (int d = 0; d < 2; d++) begin
      mem_rdata[d] <= pv[d][lat_of(d)-1] ? mem[d][pa[d][lat_of(d)-1]] : 8'($urandom);
      for (int i = 3; i > 0; i--) begin
        pv[d][i] = pv[d][i-1];
        pa[d][i] = pa[d][i-1];
      end
      pv[d][0] = mem_re[d];
      pa[d][0] = mem_addr[d];
      if (mem_we[d]) mem[d][mem_addr[d]] = mem_wdata[d];
    end
    if (tmo_seen != tmo_req) begin
      chk(1'b0, "timeout", 64'(tmo_seen), 64'(tmo_req));
      tmo_seen++;
    end
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        chk({req_ready[d], rsp_valid[d], mem_we[d], mem_re[d]} == 4'b1000, "reset_ctrl",
            64'({req_ready[d], rsp_valid[d], mem_we[d], mem_re[d]}), 64'(4'b1000));
        chk({rsp_rdata[d], mem_addr[d], mem_wdata[d]} == 40'h0, "reset_data",
            64'({rsp_rdata[d], mem_addr[d], mem_wdata[d]}), 64'h0);
        hold[d] = 0;
        exp_rdy[d] = 0;
        for (int i = 0; i < 4; i++) pv[d][i] = 0;
      end
      wq.delete();
      rq.delete();
      sq.delete();
    end else begin
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk(1'b0, "write_missing", 64'(cyc), 64'(wq[0].cyc));
        void'(wq.pop_front());
      end
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
        chk(1'b0, "read_missing", 64'(cyc), 64'(rq[0].cyc));
        void'(rq.pop_front());
      end
      if (sq.size() > 0 && sq[0].cyc < cyc && !hold[sq[0].d]) begin
        chk(1'b0, "rsp_missing", 64'(cyc), 64'(sq[0].cyc));
        void'(sq.pop_front());
      end
      for (int d = 0; d < 2; d++) begin
        if (mem_we[d] || mem_re[d])
          chk(!(mem_we[d] && mem_re[d]), "strobe_excl", 64'({mem_we[d], mem_re[d]}), 64'h0);
        if (mem_we[d]) begin
          if (wq.size() == 0 || wq[0].d != d) chk(1'b0, "unexpected_write", 64'({d[3:0], mem_addr[d]}), 64'h0);
          else begin
            e = wq.pop_front();
            chk(mem_addr[d] == e.addr && mem_wdata[d] == e.data && cyc == e.cyc, "write_byte",
                {16'(cyc), mem_addr[d], 8'h0, mem_wdata[d], 16'h0}, {16'(e.cyc), e.addr, 8'h0, e.data, 16'h0});
          end
        end
        if (mem_re[d]) begin
          if (rq.size() == 0 || rq[0].d != d) chk(1'b0, "unexpected_read", 64'({d[3:0], mem_addr[d]}), 64'h0);
          else begin
            e = rq.pop_front();
            chk(mem_addr[d] == e.addr && cyc == e.cyc, "read_issue",
                {16'(cyc), mem_addr[d]}, {16'(e.cyc), e.addr});
          end
        end
        if (exp_rdy[d]) begin
          chk(req_ready[d] == 1'b1, "ready_after_rsp", 64'(req_ready[d]), 64'h1);
          exp_rdy[d] = 0;
        end
        if (rsp_valid[d]) begin
          chk(!req_ready[d] && !mem_we[d] && !mem_re[d], "quiet_in_resp",
              64'({req_ready[d], mem_we[d], mem_re[d]}), 64'h0);
          if (!hold[d]) begin
            if (sq.size() == 0 || sq[0].d != d) chk(1'b0, "unexpected_rsp", 64'(rsp_rdata[d]), 64'h0);
            else begin
              r = sq.pop_front();
              chk(rsp_rdata[d] == r.data && cyc == r.cyc, "response",
                  {16'(cyc), rsp_rdata[d]}, {16'(r.cyc), r.data});
            end
            held[d] = rsp_rdata[d];
            hold[d] = 1;
          end else begin
            chk(rsp_rdata[d] == held[d], "rsp_hold", 64'(rsp_rdata[d]), 64'(held[d]));
          end
          if (rsp_ready[d]) begin
            hold[d] = 0;
            exp_rdy[d] = 1;
          end
        end
      end
      if (done && !finished) begin
        chk(wq.size() + rq.size() + sq.size() == 0, "drain", 64'(wq.size() + rq.size() + sq.size()), 64'h0);
        finished = 1;
      end
    end
  end

  // Present one request, wait for acceptance and push what the spec predicts.
  task automatic issue(input int d, input bit wr, input bit sg, input logic [1:0] sz,
                       input logic [15:0] addr, input logic [15:0] wd);
    int n, lat, c0, waited, v;
    logic [15:0] a;
    logic [7:0] b;
    n = (sz == 2'd0 || sz > 2'd2) ? 2 : int'(sz);
    lat = lat_of(d);
    waited = 0;
    req_valid[d] = 1'b1; req_write[d] = wr; req_signed[d] = sg;
    req_size[d] = sz; req_addr[d] = addr; req_wdata[d] = wd;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready[d] && waited < 50);
    if (!req_ready[d]) tmo_req++;
    else begin
      c0 = cyc;
      if (wr) begin
        for (int k = 0; k < n; k++) begin
          a = addr + 16'(k);
          // Memory order runs from the most significant requested byte when big-endian.
          b = be_of(d) ? 8'(wd >> (8 * (n - 1 - k))) : 8'(wd >> (8 * k));
          wq.push_back('{d, a, b, c0 + 1 + k});
          refm[d][a] = b;
        end
        sq.push_back('{d, 16'h0, c0 + n + 1});
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) begin
          a = addr + 16'(k);
          rq.push_back('{d, a, 8'h0, c0 + 1 + k * (lat + 1)});
          v = be_of(d) ? v * 256 + int'(refm[d][a]) : v + (int'(refm[d][a]) << (8 * k));
        end
        if (sg && v >= (1 << (8 * n - 1))) v = v - (1 << (8 * n));
        sq.push_back('{d, 16'(v), c0 + n * (lat + 1) + 1});
      end
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
  endtask

  // Wait for the response, hold it back for bp cycles, then accept it.
  task automatic finish_rsp(input int d, input int bp);
    int w;
    w = 0;
    rsp_ready[d] = (bp == 0);
    while (!rsp_valid[d] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!rsp_valid[d]) begin
      tmo_req++;
      rsp_ready[d] = 1'b0;
    end else begin
      if (bp > 0) begin
        repeat (bp) @(posedge clk);
        #1 rsp_ready[d] = 1'b1;
      end
      @(posedge clk);
      #1 rsp_ready[d] = 1'b0;
    end
  endtask

  task automatic txn(input int d, input bit wr, input bit sg, input logic [1:0] sz,
                     input logic [15:0] addr, input logic [15:0] wd, input int bp);
    issue(d, wr, sg, sz, addr, wd);
    finish_rsp(d, bp);
  endtask

  initial begin
    int w;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    txn(0, 1, 0, 2'd2, 16'h0100, 16'hBEEF, 0);
    txn(1, 1, 0, 2'd2, 16'h0100, 16'hBEEF, 0);
    txn(0, 0, 0, 2'd2, 16'h0100, 16'h0, 0);
    txn(1, 1, 0, 2'd2, 16'h0200, 16'h1234, 0);
    txn(0, 1, 0, 2'd2, 16'h0200, 16'h3412, 0);
    txn(1, 0, 0, 2'd2, 16'h0200, 16'h0, 0);
    txn(0, 0, 0, 2'd3, 16'h0200, 16'h0, 0);
    for (int d = 0; d < 2; d++) begin
      txn(d, 1, 0, 2'd1, 16'h0300, 16'h5580, 0);
      txn(d, 0, 1, 2'd1, 16'h0300, 16'h0, 0);
      txn(d, 0, 0, 2'd1, 16'h0300, 16'h0, 0);
      txn(d, 1, 0, 2'd0, 16'hFFFF, 16'hA55A, 0);
      txn(d, 0, 1, 2'd2, 16'hFFFF, 16'h0, 0);
      txn(d, 0, 0, 2'd2, 16'h0200, 16'h0, 5);
    end
    // Abort dut1 while it waits on byte 1, then read again.
    issue(1, 0, 0, 2'd2, 16'h0200, 16'h0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    txn(1, 0, 0, 2'd2, 16'h0200, 16'h0, 0);
    // Abort dut0 in the cycle its read strobe is high.
    issue(0, 0, 0, 2'd2, 16'h0200, 16'h0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    txn(0, 0, 0, 2'd2, 16'h0200, 16'h0, 0);
    for (int i = 0; i < 60; i++) begin
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 16'hFFF8 + 16'($urandom_range(0, 15)),
          16'($urandom), $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    #1 done = 1;
    w = 0;
    while (!finished && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
